apb_master_ctrl: RTL
====================

// Module: apb_master_ctrl
// PURPOSE
//  Requester end of the team's 4-port APB-style link. Accepts one command at a time from a local
//  client over a valid/ready handshake and drives en/wr/sel_port/addr/data toward the port-routing slave.
//  Waits for the slave's ready pulse, then returns a one-cycle response to the client.
//  Sits between the bus-client logic and the slave; one instance per link.
// PARAMETERS
//  ADDR_W       8    address width; matches slave addr_in
//  DATA_W       32   write/read data width; matches slave data_in
//  TIMEOUT_CYC  16   ACCESS cycles without ready before error (used only with APB_MASTER_TIMEOUT_EN)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous, active-low reset
//  cmd_valid  in   1       client command present
//  cmd_ready  out  1       command accepted this cycle when cmd_valid & cmd_ready
//  cmd_wr     in   1       1=write, 0=read
//  cmd_port   in   2       target port 0..3
//  cmd_addr   in   ADDR_W  target address
//  cmd_wdata  in   DATA_W  write data
//  rsp_valid  out  1       one-cycle response strobe; no back-pressure
//  rsp_rdata  out  DATA_W  rdata_in captured at completion; 0 on error
//  rsp_err    out  1       qualified by rsp_valid; 1 = timeout
//  en         out  1       transfer enable to slave
//  wr_out     out  1       to slave wr_in
//  sel_port   out  2       to slave sel_port
//  addr_out   out  ADDR_W  to slave addr_in
//  data_out   out  DATA_W  to slave data_in
//  ready      in   1       slave completion pulse
//  rdata_in   in   DATA_W  slave read data, valid while ready=1
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE. All registered outputs are 0: en, wr_out, sel_port, addr_out,
//    data_out, rsp_valid, rsp_rdata, rsp_err. Timeout counter is 0. An in-flight transfer is dropped
//    with no response.
//  - FSM states:
//    - IDLE: cmd_ready=1, combinational on state. On cmd_valid, latch wr/port/addr/wdata onto the bus
//      outputs and go to SETUP.
//    - SETUP: en=1 for one cycle; bus outputs stable. Go to ACCESS.
//    - ACCESS: en=1; bus outputs held. If ready=1: rsp_valid=1, rsp_rdata=rdata_in (writes: rdata_in
//      captured as-is), rsp_err=0; go to RELEASE.
//    - RELEASE: en=0 for exactly one cycle so the slave leaves its WAIT state; rsp_valid back to 0;
//      go to IDLE.
//  - en, wr_out, sel_port, addr_out and data_out are registered; no output depends combinationally on ready.
//  - cmd_ready is 0 in SETUP, ACCESS and RELEASE. cmd_valid presented there is ignored and not stored;
//    the client must hold it.
//  - Latency: accept edge -> en high next cycle. With the team slave, ready arrives 2 cycles after en
//    rises; rsp_valid follows 1 cycle later. Back-to-back issue rate is 1 command per 5 cycles.
//  - ready seen in IDLE, SETUP or RELEASE is ignored; it is never counted as a completion.
//  - Bus outputs keep their last values after RELEASE until the next accept; en=0 qualifies them.
// CONFIGURATION
//  - APB_MASTER_TIMEOUT_EN defined:
//    - An $clog2(TIMEOUT_CYC+1)-bit counter clears on entry to ACCESS and increments each ACCESS cycle
//      with ready=0.
//    - On reaching TIMEOUT_CYC: rsp_valid=1, rsp_err=1, rsp_rdata=0; go to RELEASE.
//    - If ready=1 on the same cycle, ready wins and rsp_err=0.
//  - APB_MASTER_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; rsp_err is tied to 0.
// STRUCTURE
//  - Shared package apb_pkg: state enum (IDLE/SETUP/ACCESS/RELEASE), port-select constants
//    PORT1..PORT4 = 2'd0..3, and default ADDR_W/DATA_W localparams shared with the slave.
//  - Single flat module; the timeout counter is inline. No sub-module.
// TESTING
//  1. Reset mid-ACCESS: pull rst low with en=1 -> en, rsp_valid and all bus outputs 0 immediately;
//     no rsp after release; cmd_ready=1.
//  2. Write port 2, addr 8'h3C, data 32'hDEADBEEF, against the slave model -> slave data_out3=DEADBEEF,
//     addr_out3=3C; rsp_valid one cycle; rsp_err=0; en low exactly one cycle afterwards.
//  3. Back-to-back: cmd_valid held with ports 0,1,2,3 -> four responses 5 cycles apart, each routed
//     to the correct slave port; cmd_ready low between accepts.
//  4. Read with ready delayed 7 cycles and rdata_in=32'h12345678 -> rsp_rdata=12345678; en high
//     throughout the wait.
//  5. With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYC=4, ready never asserted -> rsp_err=1, rsp_rdata=0,
//     4 ACCESS cycles; then ready at count 4 -> rsp_err=0.
//  6. Spurious ready=1 while IDLE and during SETUP -> no rsp_valid; the next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the 4-port APB-style link: transfer states, port-select codes
// and the default bus widths used by both the master and the port-routing slave.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    localparam logic [1:0] PORT1 = 2'd0;
    localparam logic [1:0] PORT2 = 2'd1;
    localparam logic [1:0] PORT3 = 2'd2;
    localparam logic [1:0] PORT4 = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RELEASE = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_master_ctrl.sv
// Requester end of the 4-port APB-style link: one client command at a time, one-cycle response.
// Optional ACCESS timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [1:0]        cmd_port,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              en,
    output logic              wr_out,
    output logic [1:0]        sel_port,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ready,
    input  logic [DATA_W-1:0] rdata_in
);

    apb_state_e        state_q;
    logic              en_q;
    logic              wr_q;
    logic [1:0]        port_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             rsp_err_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            wr_q        <= 1'b0;
            port_q      <= PORT1;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        wr_q    <= cmd_wr;
                        port_q  <= cmd_port;
                        addr_q  <= cmd_addr;
                        data_q  <= cmd_wdata;
                        en_q    <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                ACCESS: begin
                    // A ready on the final counted cycle still completes normally.
                    if (ready) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_in;
                        en_q        <= 1'b0;
                        state_q     <= RELEASE;
`ifdef APB_MASTER_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q       <= cnt_q + CNT_W'(1);
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        en_q        <= 1'b0;
                        state_q     <= RELEASE;
                    end else begin
                        cnt_q       <= cnt_q + CNT_W'(1);
`endif
                    end
                end
                RELEASE: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign en        = en_q;
    assign wr_out    = wr_q;
    assign sel_port  = port_q;
    assign addr_out  = addr_q;
    assign data_out  = data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
